// File: rtl/lsu_pkg.sv
// Shared func3 codes, FSM/size types and small decode helpers for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

   // Only the low two func3 bits carry the width; bit 2 is the unsigned flag.
   function automatic size_e func3_size(input logic [1:0] f3_lo);
      case (f3_lo)
         2'b00:   return SzByte;
         2'b01:   return SzHalf;
         default: return SzWord;
      endcase
   endfunction

   function automatic logic [3:0] size_mask(input size_e sz);
      case (sz)
         SzByte:  return 4'b0001;
         SzHalf:  return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [2:0] size_bytes(input size_e sz);
      case (sz)
         SzByte:  return 3'd1;
         SzHalf:  return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic func3_legal(input logic we, input logic [2:0] f3);
      if (we) return f3 inside {F3_SB, F3_SH, F3_SW};
      return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and write data for both beats, plus load
// extraction and sign/zero extension from the two-word beat buffer.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] buf0,
   input  logic [31:0] buf1,
   output logic [3:0]  be0,
   output logic [3:0]  be1,
   output logic [31:0] wdata0,
   output logic [31:0] wdata1,
   output logic [31:0] rdata
);

   size_e       size;
   logic [4:0]  shamt;
   logic [7:0]  be_wide;
   logic [63:0] wdata_wide;
   logic [31:0] shifted;

   assign size       = func3_size(func3[1:0]);
   assign shamt      = {offset, 3'b000};
   assign be_wide    = {4'b0000, size_mask(size)} << offset;
   assign wdata_wide = {32'h0, wdata} << shamt;
   assign shifted    = 32'({buf1, buf0} >> shamt);

   assign be0    = be_wide[3:0];
   assign be1    = be_wide[7:4];
   assign wdata0 = wdata_wide[31:0];
   assign wdata1 = wdata_wide[63:32];

   // func3[2] set means LBU/LHU: suppress sign replication.
   always_comb begin
      rdata = shifted;
      case (size)
         SzByte:  rdata = {{24{~func3[2] & shifted[7]}}, shifted[7:0]};
         SzHalf:  rdata = {{16{~func3[2] & shifted[15]}}, shifted[15:0]};
         default: rdata = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding req/gnt/rvalid transaction to data memory.
// Define LSU_MISALIGN_EN to split word-crossing accesses into two beats instead of faulting.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_func3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        func3_q, func3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] buf0_q, buf0_d;
   logic              err_q, err_d;

   logic [3:0]        be0, be1, cur_be;
   logic [DATA_W-1:0] wdata0, wdata1, cur_wdata, load_data, buf1;
   logic [ADDR_W-1:0] word_addr, cur_addr;
   logic              req_fault;

   assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_EN
   logic              beat_q, beat_d;
   logic [DATA_W-1:0] buf1_q, buf1_d;
   logic              cross;

   assign req_fault = !func3_legal(req_we, req_func3);
   assign cross     = ({1'b0, addr_q[1:0]} + size_bytes(func3_size(func3_q[1:0]))) > 3'd4;
   assign buf1      = buf1_q;
   assign cur_be    = beat_q ? be1 : be0;
   assign cur_wdata = beat_q ? wdata1 : wdata0;
   assign cur_addr  = word_addr + {{(ADDR_W-3){1'b0}}, beat_q, 2'b00};
`else
   size_e req_size;
   logic  misalign;
   logic  unused_beat1;

   assign req_size  = func3_size(req_func3[1:0]);
   assign misalign  = (req_size == SzHalf && req_addr[0]) ||
                      (req_size == SzWord && req_addr[1:0] != 2'b00);
   assign req_fault = !func3_legal(req_we, req_func3) || misalign;
   assign buf1      = '0;
   assign cur_be    = be0;
   assign cur_wdata = wdata0;
   assign cur_addr  = word_addr;
   assign unused_beat1 = ^{be1, wdata1};
`endif

   lsu_align u_align (
      .func3  (func3_q),
      .offset (addr_q[1:0]),
      .wdata  (wdata_q),
      .buf0   (buf0_q),
      .buf1   (buf1),
      .be0    (be0),
      .be1    (be1),
      .wdata0 (wdata0),
      .wdata1 (wdata1),
      .rdata  (load_data)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      func3_d = func3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      buf0_d  = buf0_q;
`ifdef LSU_MISALIGN_EN
      beat_d  = beat_q;
      buf1_d  = buf1_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               we_d    = req_we;
               func3_d = req_func3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = req_fault;
               state_d = req_fault ? StResp : StIssue;
`ifdef LSU_MISALIGN_EN
               beat_d  = 1'b0;
`endif
            end
         end
         StIssue: begin
            if (mem_gnt) state_d = StWait;
         end
         StWait: begin
            if (mem_rvalid) begin
`ifdef LSU_MISALIGN_EN
               if (beat_q) buf1_d = mem_rdata;
               else        buf0_d = mem_rdata;
               if (!beat_q && cross) begin
                  beat_d  = 1'b1;
                  state_d = StIssue;
               end else begin
                  state_d = StResp;
               end
`else
               buf0_d  = mem_rdata;
               state_d = StResp;
`endif
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         func3_q <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         buf0_q  <= '0;
`ifdef LSU_MISALIGN_EN
         beat_q  <= 1'b0;
         buf1_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         func3_q <= func3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         buf0_q  <= buf0_d;
`ifdef LSU_MISALIGN_EN
         beat_q  <= beat_d;
         buf1_q  <= buf1_d;
`endif
      end
   end

   // Memory-side fields are forced to zero outside ISSUE so idle buses stay quiet.
   assign req_ready = (state_q == StIdle);
   assign mem_req   = (state_q == StIssue);
   assign mem_we    = mem_req & we_q;
   assign mem_addr  = mem_req ? cur_addr : '0;
   assign mem_be    = mem_req ? cur_be : 4'b0000;
   assign mem_wdata = mem_req ? cur_wdata : '0;
   assign rsp_valid = (state_q == StResp);
   assign rsp_err   = rsp_valid & err_q;
   assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed transactions queue expected memory beats
// and responses; negedge monitors pop and compare them against the DUT outputs.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_func3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_req, mem_gnt, mem_we, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_func3  (req_func3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_req    (mem_req),
      .mem_gnt    (mem_gnt),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic        chk_wd;
      string       name;
   } beat_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
      string       name;
   } rsp_t;

   beat_t       mq[$];
   rsp_t        rq[$];
   beat_t       mb;
   rsp_t        mr;
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   bit          mon_en = 0;
   int          gnt_delay = 0;
   bit          drop_rvalid = 0;
   bit          inject_rvalid = 0;
   logic [31:0] mem [4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: optional grant delay, rvalid one cycle after grant.
   initial begin
      int          wcnt;
      bit          pend;
      logic [31:0] pend_data;
      wcnt = 0;
      pend = 0;
      pend_data = '0;
      mem_gnt = 0;
      mem_rvalid = 0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_gnt = 0;
         mem_rvalid = 0;
         if (inject_rvalid) begin
            mem_rvalid = 1;
            mem_rdata = 32'hBAD0_BAD0;
            inject_rvalid = 0;
         end else if (pend) begin
            mem_rvalid = 1;
            mem_rdata = pend_data;
            pend = 0;
         end else if (mem_req === 1'b1) begin
            if (wcnt < gnt_delay) begin
               wcnt++;
            end else begin
               mem_gnt = 1;
               wcnt = 0;
               if (mem_we)
                  for (int b = 0; b < 4; b++)
                     if (mem_be[b]) mem[mem_addr[3:2]][8*b +: 8] = mem_wdata[8*b +: 8];
               pend_data = mem[mem_addr[3:2]];
               pend = !drop_rvalid;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_req === 1'b1) begin
            n_tests++;
            if (mq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_mem_req: got addr=%h be=%b, required no request",
                        mem_addr, mem_be);
            end else begin
               mb = mq[0];
               if (mem_addr !== mb.addr || mem_be !== mb.be || mem_we !== mb.we ||
                   (mb.chk_wd && mem_wdata !== mb.wdata)) begin
                  n_fail++;
                  $display("FAIL %s beat: got addr=%h be=%b we=%b wdata=%h, required addr=%h be=%b we=%b wdata=%h",
                           mb.name, mem_addr, mem_be, mem_we, mem_wdata,
                           mb.addr, mb.be, mb.we, mb.wdata);
               end
               if (mem_gnt) void'(mq.pop_front());
            end
         end
         if (rsp_valid === 1'b1) begin
            n_tests++;
            if (rq.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_rsp: got err=%b rdata=%h, required no response",
                        rsp_err, rsp_rdata);
            end else begin
               mr = rq.pop_front();
               if (rsp_err !== mr.err || rsp_rdata !== mr.rdata || cyc != mr.cyc ||
                   req_ready !== 1'b0) begin
                  n_fail++;
                  $display("FAIL %s rsp: got err=%b rdata=%h cycle=%0d ready=%b, required err=%b rdata=%h cycle=%0d ready=0",
                           mr.name, rsp_err, rsp_rdata, cyc, req_ready,
                           mr.err, mr.rdata, mr.cyc);
               end
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, got, exp);
      end
   endtask

   task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic we,
                            input logic [31:0] wd, input logic chk, input string nm);
      beat_t b;
      b.addr = a;
      b.be = be;
      b.we = we;
      b.wdata = wd;
      b.chk_wd = chk;
      b.name = nm;
      mq.push_back(b);
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int acc);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (req_ready !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: got req_ready=%b, required 1", req_ready);
      end
      req_valid = 1;
      req_we = we;
      req_func3 = f3;
      req_addr = a;
      req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 0;
      acc = cyc;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((rq.size() != 0 || mq.size() != 0) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (rq.size() != 0 || mq.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s timeout: got %0d rsp and %0d beats outstanding, required 0",
                  nm, rq.size(), mq.size());
         rq.delete();
         mq.delete();
      end
   endtask

   // lat = cycles from the first cycle after the accept edge to the response cycle.
   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic err, input logic [31:0] rd,
                       input int lat, input string nm);
      int   acc;
      rsp_t r;
      issue(we, f3, a, wd, acc);
      r.err = err;
      r.rdata = rd;
      r.cyc = acc + lat;
      r.name = nm;
      rq.push_back(r);
      drain(nm);
   endtask

   initial begin
      int acc;
      rst_n = 0;
      req_valid = 0;
      req_we = 0;
      req_func3 = 3'b000;
      req_addr = '0;
      req_wdata = '0;
      for (int i = 0; i < 4; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", {31'h0, req_ready}, 32'h1);
      check("reset_ctl", {28'h0, mem_req, mem_we, rsp_valid, rsp_err}, 32'h0);
      check("reset_be", {28'h0, mem_be}, 32'h0);
      check("reset_addr", mem_addr, 32'h0);
      check("reset_wdata", mem_wdata, 32'h0);
      check("reset_rdata", rsp_rdata, 32'h0);
      rst_n = 1;
      mon_en = 1;

      push_beat(32'h0, 4'b1111, 1, 32'hDEADBEEF, 1, "sw");
      xact(1, 3'b010, 32'h0, 32'hDEADBEEF, 0, 32'h0, 2, "sw");
      push_beat(32'h0, 4'b1111, 0, 32'h0, 0, "lw");
      xact(0, 3'b010, 32'h0, 32'h0, 0, 32'hDEADBEEF, 2, "lw");
      push_beat(32'h0, 4'b0001, 0, 32'h0, 0, "lb");
      xact(0, 3'b000, 32'h0, 32'h0, 0, 32'hFFFFFFEF, 2, "lb");
      push_beat(32'h0, 4'b0001, 0, 32'h0, 0, "lbu");
      xact(0, 3'b100, 32'h0, 32'h0, 0, 32'h000000EF, 2, "lbu");
      push_beat(32'h0, 4'b1100, 0, 32'h0, 0, "lh2");
      xact(0, 3'b001, 32'h2, 32'h0, 0, 32'hFFFFDEAD, 2, "lh2");
      push_beat(32'h0, 4'b0011, 0, 32'h0, 0, "lhu");
      xact(0, 3'b101, 32'h0, 32'h0, 0, 32'h0000BEEF, 2, "lhu");
      push_beat(32'h4, 4'b0010, 1, 32'h0000AA00, 1, "sb5");
      xact(1, 3'b000, 32'h5, 32'h000000AA, 0, 32'h0, 2, "sb5");
      push_beat(32'h4, 4'b1100, 1, 32'h12340000, 1, "sh6");
      xact(1, 3'b001, 32'h6, 32'h00001234, 0, 32'h0, 2, "sh6");
      push_beat(32'h4, 4'b1111, 0, 32'h0, 0, "lw4");
      xact(0, 3'b010, 32'h4, 32'h0, 0, 32'h1234AA00, 2, "lw4");
      xact(0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 0, "ld_illegal");
      xact(1, 3'b100, 32'h0, 32'h5555_5555, 1, 32'h0, 0, "st_illegal");

      mem[0] = 32'h11223344;
      mem[1] = 32'h55667788;
`ifdef LSU_MISALIGN_EN
      push_beat(32'h0, 4'b1100, 0, 32'h0, 0, "lw2_b0");
      push_beat(32'h4, 4'b0011, 0, 32'h0, 0, "lw2_b1");
      xact(0, 3'b010, 32'h2, 32'h0, 0, 32'h77881122, 4, "lw2");
      push_beat(32'h0, 4'b0110, 0, 32'h0, 0, "lh1");
      xact(0, 3'b001, 32'h1, 32'h0, 0, 32'h00002233, 2, "lh1");
      push_beat(32'h0, 4'b1000, 0, 32'h0, 0, "lh3_b0");
      push_beat(32'h4, 4'b0001, 0, 32'h0, 0, "lh3_b1");
      xact(0, 3'b001, 32'h3, 32'h0, 0, 32'hFFFF8811, 4, "lh3");
`else
      xact(0, 3'b010, 32'h2, 32'h0, 1, 32'h0, 0, "lw2");
      xact(0, 3'b001, 32'h1, 32'h0, 1, 32'h0, 0, "lh1");
      xact(0, 3'b001, 32'h3, 32'h0, 1, 32'h0, 0, "lh3");
`endif
      push_beat(32'h0, 4'b1000, 0, 32'h0, 0, "lbu3");
      xact(0, 3'b100, 32'h3, 32'h0, 0, 32'h00000011, 2, "lbu3");

      gnt_delay = 3;
      push_beat(32'h4, 4'b1111, 0, 32'h0, 0, "lw_gnt3");
      xact(0, 3'b010, 32'h4, 32'h0, 0, 32'h55667788, 5, "lw_gnt3");
      gnt_delay = 0;

      // Reset while waiting for rvalid: no response, bus idle, late rvalid ignored.
      drop_rvalid = 1;
      push_beat(32'h0, 4'b1111, 0, 32'h0, 0, "lw_rst");
      issue(0, 3'b010, 32'h0, 32'h0, acc);
      @(posedge clk);
      #1;
      rst_n = 0;
      @(posedge clk);
      #1;
      check("rst_mid_idle", {29'h0, mem_req, rsp_valid, req_ready}, 32'h1);
      rst_n = 1;
      drop_rvalid = 0;
      inject_rvalid = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("rst_late_rvalid", {29'h0, mem_req, rsp_valid, req_ready}, 32'h1);
      end
      check("rst_beats_left", mq.size(), 32'h0);

      push_beat(32'h4, 4'b1111, 0, 32'h0, 0, "lw_recover");
      xact(0, 3'b010, 32'h4, 32'h0, 0, 32'h55667788, 2, "lw_recover");
`ifdef LSU_MISALIGN_EN
      push_beat(32'h0, 4'b1000, 1, 32'hD4000000, 1, "sw3_b0");
      push_beat(32'h4, 4'b0111, 1, 32'h00A1B2C3, 1, "sw3_b1");
      xact(1, 3'b010, 32'h3, 32'hA1B2C3D4, 0, 32'h0, 4, "sw3");
      push_beat(32'h4, 4'b1111, 0, 32'h0, 0, "lw4_after");
      xact(0, 3'b010, 32'h4, 32'h0, 0, 32'h55A1B2C3, 2, "lw4_after");
`else
      xact(1, 3'b010, 32'h3, 32'hA1B2C3D4, 1, 32'h0, 0, "sw3");
      push_beat(32'h4, 4'b1111, 0, 32'h0, 0, "lw4_after");
      xact(0, 3'b010, 32'h4, 32'h0, 0, 32'h55667788, 2, "lw4_after");
`endif

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
